// File: rtl/matmul_job_seq_if.sv
// Host/engine-facing bundle of the matmul job sequencer. The slave modport is
// the sequencer's view; the master modport is the view of whatever drives it
// (host command side plus the engine's ret/mem_req responses).
interface matmul_job_seq_if #(
    parameter int MEM_AW   = 16,
    parameter int DIM_BITS = 16,
    parameter int TAG_W    = 8,
    parameter int DEPTH    = 4
);
    localparam int CMD_W = 3*MEM_AW + 6*DIM_BITS;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                cmd_vld;
    logic                cmd_rdy;
    logic [CMD_W-1:0]    cmd_data;
    logic [TAG_W-1:0]    cmd_tag;
    logic [MEM_AW-1:0]   aBASE;
    logic [MEM_AW-1:0]   bBASE;
    logic [MEM_AW-1:0]   cBASE;
    logic [DIM_BITS-1:0] aSTRIDE;
    logic [DIM_BITS-1:0] bSTRIDE;
    logic [DIM_BITS-1:0] cSTRIDE;
    logic [DIM_BITS-1:0] aROWS;
    logic [DIM_BITS-1:0] aCOLS;
    logic [DIM_BITS-1:0] bCOLS;
    logic                go;
    logic                ret;
    logic                mem_req;
    logic                done_vld;
    logic [TAG_W-1:0]    done_tag;
    logic                busy;
    logic [15:0]         jobs_done;
    logic [LVL_W-1:0]    fifo_level;

    modport slave (
        input  cmd_vld, cmd_data, cmd_tag, ret, mem_req,
        output cmd_rdy, aBASE, bBASE, cBASE, aSTRIDE, bSTRIDE, cSTRIDE,
               aROWS, aCOLS, bCOLS, go, done_vld, done_tag, busy,
               jobs_done, fifo_level
    );

    modport master (
        output cmd_vld, cmd_data, cmd_tag, ret, mem_req,
        input  cmd_rdy, aBASE, bBASE, cBASE, aSTRIDE, bSTRIDE, cSTRIDE,
               aROWS, aCOLS, bCOLS, go, done_vld, done_tag, busy,
               jobs_done, fifo_level
    );
endinterface

// File: rtl/matmul_job_seq.sv
// Job sequencer in front of the matmul engine: queues descriptors, loads the
// engine parameters, holds go until the engine shows it started, and reports
// one tagged completion per job. Jobs with no rows or no output columns are
// completed without starting the engine.
module matmul_job_seq #(
    parameter int MEM_AW   = 16,
    parameter int DIM_BITS = 16,
    parameter int TAG_W    = 8,
    parameter int DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    matmul_job_seq_if.slave   bus
);
    localparam int CMD_W = 3*MEM_AW + 6*DIM_BITS;
    localparam int ENT_W = CMD_W + TAG_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // FIFO entry layout: {cmd_data, cmd_tag}
    localparam int B_COLS_LSB = TAG_W;
    localparam int A_COLS_LSB = TAG_W + DIM_BITS;
    localparam int A_ROWS_LSB = TAG_W + 2*DIM_BITS;
    localparam int C_STR_LSB  = TAG_W + 3*DIM_BITS;
    localparam int B_STR_LSB  = TAG_W + 4*DIM_BITS;
    localparam int A_STR_LSB  = TAG_W + 5*DIM_BITS;
    localparam int C_BASE_LSB = TAG_W + 6*DIM_BITS;
    localparam int B_BASE_LSB = TAG_W + 6*DIM_BITS + MEM_AW;
    localparam int A_BASE_LSB = TAG_W + 6*DIM_BITS + 2*MEM_AW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        SKIP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [ENT_W-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]    level_r, level_s;
    logic [ENT_W-1:0]    head_s;
    logic                push_s, pop_s, head_run_s, go_s;
    logic                cmd_rdy_r, go_r, done_vld_r, busy_r;
    logic [TAG_W-1:0]    job_tag_r, done_tag_r;
    logic [15:0]         jobs_done_r;
    logic [MEM_AW-1:0]   a_base_r, b_base_r, c_base_r;
    logic [DIM_BITS-1:0] a_stride_r, b_stride_r, c_stride_r;
    logic [DIM_BITS-1:0] a_rows_r, a_cols_r, b_cols_r;

    assign push_s     = bus.cmd_vld & cmd_rdy_r;
    assign pop_s      = (state_r == IDLE) && (level_r != LVL_W'(0));
    assign head_s     = mem_r[rd_ptr_r];
    // The engine is only started when the job produces at least one output.
    assign head_run_s = (head_s[A_ROWS_LSB +: DIM_BITS] != '0) &&
                        (head_s[B_COLS_LSB +: DIM_BITS] != '0);

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_W'(1);
            2'b01:   level_s = level_r - LVL_W'(1);
            default: level_s = level_r;
        endcase
    end

    // Next state and next go level; go is raised as the job is popped so the
    // engine sees it while the parameters settle in LOAD.
    always_comb begin
        state_s = state_r;
        go_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_s = LOAD;
                    go_s    = head_run_s;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if ((a_rows_r == '0) || (b_cols_r == '0)) begin
                    state_s = SKIP;
                end else begin
                    state_s = LAUNCH;
                    go_s    = 1'b1;
                end
            end
            LAUNCH: begin
                if (bus.ret) begin
                    state_s = DONE;
                end else if (bus.mem_req) begin
                    state_s = RUN;
                end else begin
                    state_s = LAUNCH;
                    go_s    = 1'b1;
                end
            end
            RUN: begin
                if (bus.ret) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            SKIP:    state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Descriptor storage; contents need no reset because level gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_data, bus.cmd_tag};
        end
    end

    // FIFO pointers, occupancy and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            cmd_rdy_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            level_r   <= level_s;
            cmd_rdy_r <= (level_s != LVL_W'(DEPTH));
        end
    end

    // Control state, handshake outputs and the completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            go_r        <= 1'b0;
            done_vld_r  <= 1'b0;
            done_tag_r  <= '0;
            jobs_done_r <= 16'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            go_r       <= go_s;
            done_vld_r <= (state_s == DONE);
            busy_r     <= !((state_s == IDLE) && (level_s == LVL_W'(0)));
            if (state_s == DONE) begin
                done_tag_r  <= job_tag_r;
                jobs_done_r <= jobs_done_r + 16'd1;
            end
        end
    end

    // Engine parameters and job tag: captured on pop, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_base_r   <= '0;
            b_base_r   <= '0;
            c_base_r   <= '0;
            a_stride_r <= '0;
            b_stride_r <= '0;
            c_stride_r <= '0;
            a_rows_r   <= '0;
            a_cols_r   <= '0;
            b_cols_r   <= '0;
            job_tag_r  <= '0;
        end else if (pop_s) begin
            a_base_r   <= head_s[A_BASE_LSB +: MEM_AW];
            b_base_r   <= head_s[B_BASE_LSB +: MEM_AW];
            c_base_r   <= head_s[C_BASE_LSB +: MEM_AW];
            a_stride_r <= head_s[A_STR_LSB  +: DIM_BITS];
            b_stride_r <= head_s[B_STR_LSB  +: DIM_BITS];
            c_stride_r <= head_s[C_STR_LSB  +: DIM_BITS];
            a_rows_r   <= head_s[A_ROWS_LSB +: DIM_BITS];
            a_cols_r   <= head_s[A_COLS_LSB +: DIM_BITS];
            b_cols_r   <= head_s[B_COLS_LSB +: DIM_BITS];
            job_tag_r  <= head_s[TAG_W-1:0];
        end
    end

    assign bus.cmd_rdy    = cmd_rdy_r;
    assign bus.go         = go_r;
    assign bus.done_vld   = done_vld_r;
    assign bus.done_tag   = done_tag_r;
    assign bus.busy       = busy_r;
    assign bus.jobs_done  = jobs_done_r;
    assign bus.fifo_level = level_r;
    assign bus.aBASE      = a_base_r;
    assign bus.bBASE      = b_base_r;
    assign bus.cBASE      = c_base_r;
    assign bus.aSTRIDE    = a_stride_r;
    assign bus.bSTRIDE    = b_stride_r;
    assign bus.cSTRIDE    = c_stride_r;
    assign bus.aROWS      = a_rows_r;
    assign bus.aCOLS      = a_cols_r;
    assign bus.bCOLS      = b_cols_r;
endmodule

// File: tb/tb_matmul_job_seq.sv
// Directed bench for matmul_job_seq: single job timing, back-to-back queueing,
// degenerate jobs, ret without mem_req, mid-job reset and counter wrap.
module tb_matmul_job_seq;
    localparam int CMD_W = 144;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errs = 0;
    int   go_starts = 0;
    int   done_count = 0;
    logic go_prev = 1'b0;
    logic [15:0] exp_jobs = 16'd0;
    int   snap_go, snap_done;

    matmul_job_seq_if bus();

    matmul_job_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Counts engine starts (go rising edges) and completion pulses.
    always @(posedge clk) begin
        if (bus.go && !go_prev) go_starts = go_starts + 1;
        go_prev = bus.go;
        if (bus.done_vld) done_count = done_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [15:0] ab, input logic [15:0] bb,
                                            input logic [15:0] cb, input logic [15:0] as_,
                                            input logic [15:0] bs, input logic [15:0] cs,
                                            input logic [15:0] ar, input logic [15:0] ac,
                                            input logic [15:0] bc);
        return {ab, bb, cb, as_, bs, cs, ar, ac, bc};
    endfunction

    // Waits for room, then presents the descriptor for exactly one accepted cycle.
    task automatic push(input logic [CMD_W-1:0] d, input logic [7:0] t);
        int n = 0;
        while (!bus.cmd_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_rdy_wait", {31'd0, bus.cmd_rdy}, 32'd1);
        bus.cmd_vld  = 1'b1;
        bus.cmd_data = d;
        bus.cmd_tag  = t;
        tick();
        bus.cmd_vld  = 1'b0;
    endtask

    // Engine stand-in: waits for go, answers with mem_req then ret (mode 0)
    // or with ret alone (mode 1), then checks the completion.
    task automatic serve(input logic [15:0] exp_abase, input logic [7:0] exp_tag, input int mode);
        int n = 0;
        while (!bus.go && n < 30) begin
            tick();
            n++;
        end
        chk("go_seen", {31'd0, bus.go}, 32'd1);
        chk("aBASE", {16'd0, bus.aBASE}, {16'd0, exp_abase});
        tick();
        chk("go_held", {31'd0, bus.go}, 32'd1);
        if (mode == 0) begin
            bus.mem_req = 1'b1;
            tick();
            bus.mem_req = 1'b0;
            chk("go_drop", {31'd0, bus.go}, 32'd0);
            tick();
            tick();
            chk("done_early", {31'd0, bus.done_vld}, 32'd0);
            bus.ret = 1'b1;
            tick();
            bus.ret = 1'b0;
        end else begin
            bus.ret = 1'b1;
            tick();
            bus.ret = 1'b0;
            chk("go_drop_ret", {31'd0, bus.go}, 32'd0);
        end
        exp_jobs = exp_jobs + 16'd1;
        chk("done_vld", {31'd0, bus.done_vld}, 32'd1);
        chk("done_tag", {24'd0, bus.done_tag}, {24'd0, exp_tag});
        chk("jobs_done", {16'd0, bus.jobs_done}, {16'd0, exp_jobs});
        tick();
        chk("done_pulse", {31'd0, bus.done_vld}, 32'd0);
    endtask

    initial begin
        bus.cmd_vld  = 1'b0;
        bus.cmd_data = '0;
        bus.cmd_tag  = 8'd0;
        bus.ret      = 1'b0;
        bus.mem_req  = 1'b0;

        // 1: reset state, then single 2x2*2x2 job
        tick(); tick(); tick();
        chk("rst_go", {31'd0, bus.go}, 32'd0);
        chk("rst_done", {31'd0, bus.done_vld}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("rst_jobs", {16'd0, bus.jobs_done}, 32'd0);
        chk("rst_level", {29'd0, bus.fifo_level}, 32'd0);
        chk("rst_aBASE", {16'd0, bus.aBASE}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", {31'd0, bus.cmd_rdy}, 32'd1);
        push(mk(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd3, 16'd4, 16'd2, 16'd2, 16'd2), 8'h11);
        chk("j1_level", {29'd0, bus.fifo_level}, 32'd1);
        chk("j1_go_n1", {31'd0, bus.go}, 32'd0);
        chk("j1_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("j1_go_n2", {31'd0, bus.go}, 32'd1);
        chk("j1_bBASE", {16'd0, bus.bBASE}, 32'h0200);
        chk("j1_cBASE", {16'd0, bus.cBASE}, 32'h0300);
        chk("j1_aSTRIDE", {16'd0, bus.aSTRIDE}, 32'd2);
        chk("j1_bSTRIDE", {16'd0, bus.bSTRIDE}, 32'd3);
        chk("j1_cSTRIDE", {16'd0, bus.cSTRIDE}, 32'd4);
        chk("j1_aROWS", {16'd0, bus.aROWS}, 32'd2);
        chk("j1_aCOLS", {16'd0, bus.aCOLS}, 32'd2);
        chk("j1_bCOLS", {16'd0, bus.bCOLS}, 32'd2);
        chk("j1_level0", {29'd0, bus.fifo_level}, 32'd0);
        tick(); tick();
        chk("j1_go_hold", {31'd0, bus.go}, 32'd1);
        serve(16'h0100, 8'h11, 0);
        chk("j1_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("j1_param_hold", {16'd0, bus.aBASE}, 32'h0100);

        // 2: five back-to-back jobs into a 4-deep FIFO
        snap_go = go_starts;
        for (int i = 0; i < 5; i++) begin
            push(mk(16'h1000 + 16'(i), 16'h2000, 16'h3000, 16'd1, 16'd1, 16'd1,
                    16'd1, 16'd1, 16'd1), 8'h31 + 8'(i));
        end
        chk("q_full_level", {29'd0, bus.fifo_level}, 32'd4);
        chk("q_full_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            serve(16'h1000 + 16'(i), 8'h31 + 8'(i), 0);
        end
        chk("q_go_count", go_starts - snap_go, 32'd5);

        // 3: aROWS==0 is skipped, aCOLS==0 is launched
        snap_go = go_starts;
        push(mk(16'h4000, 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd0, 16'd3, 16'd3), 8'h22);
        chk("skip_go_pop", {31'd0, bus.go}, 32'd0);
        tick();
        chk("skip_go_load", {31'd0, bus.go}, 32'd0);
        tick();
        chk("skip_done_early", {31'd0, bus.done_vld}, 32'd0);
        tick();
        exp_jobs = exp_jobs + 16'd1;
        chk("skip_done", {31'd0, bus.done_vld}, 32'd1);
        chk("skip_tag", {24'd0, bus.done_tag}, 32'h22);
        chk("skip_jobs", {16'd0, bus.jobs_done}, {16'd0, exp_jobs});
        chk("skip_no_go", go_starts - snap_go, 32'd0);
        push(mk(16'h4100, 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'd2), 8'h23);
        serve(16'h4100, 8'h23, 0);

        // 4: ret with no mem_req while in LAUNCH
        snap_go = go_starts;
        push(mk(16'h5000, 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1), 8'h44);
        serve(16'h5000, 8'h44, 1);
        tick(); tick(); tick();
        chk("retonly_go_idle", {31'd0, bus.go}, 32'd0);
        chk("retonly_starts", go_starts - snap_go, 32'd1);

        // 5: reset mid-RUN with three jobs queued
        push(mk(16'h6000, 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2), 8'h55);
        while (!bus.go) tick();
        tick();
        bus.mem_req = 1'b1;
        tick();
        bus.mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(mk(16'h6100 + 16'(i), 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1),
                 8'h56 + 8'(i));
        end
        chk("mid_level", {29'd0, bus.fifo_level}, 32'd3);
        chk("mid_go", {31'd0, bus.go}, 32'd0);
        snap_done = done_count;
        rst = 1'b1;
        tick();
        chk("mrst_level", {29'd0, bus.fifo_level}, 32'd0);
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_jobs", {16'd0, bus.jobs_done}, 32'd0);
        chk("mrst_aBASE", {16'd0, bus.aBASE}, 32'd0);
        chk("mrst_aROWS", {16'd0, bus.aROWS}, 32'd0);
        tick();
        rst = 1'b0;
        exp_jobs = 16'd0;
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        tick(); tick();
        chk("mrst_no_done", done_count - snap_done, 32'd0);
        chk("mrst_idle_go", {31'd0, bus.go}, 32'd0);
        chk("mrst_idle_busy", {31'd0, bus.busy}, 32'd0);
        push(mk(16'h7000, 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd3, 16'd1, 16'd2), 8'h66);
        serve(16'h7000, 8'h66, 0);

        // 6: counter wraps from 0xFFFF to 0
        force dut.jobs_done_r = 16'hFFFF;
        tick();
        release dut.jobs_done_r;
        tick();
        push(mk(16'h8000, 16'h0, 16'h0, 16'd1, 16'd1, 16'd1, 16'd4, 16'd4, 16'd0), 8'h77);
        tick(); tick(); tick();
        chk("wrap_done", {31'd0, bus.done_vld}, 32'd1);
        chk("wrap_tag", {24'd0, bus.done_tag}, 32'h77);
        chk("wrap_jobs", {16'd0, bus.jobs_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
